// File: rtl/col_parity_pkg.sv
// col_parity_pkg: shared types and defaults for the column-parity sequencer
package col_parity_pkg;
    localparam int PAGES_DEF   = 64;
    localparam int IDX_W_DEF   = 6;
    localparam int MEM_LAT_DEF = 1;
    localparam int SLICE_W     = 25;

    typedef enum logic [2:0] {
        IDLE, PRE_FETCH, PRE_LATCH, FETCH, LATCH, COMPUTE, WRITE, DONE
    } state_e;

    function automatic logic is_wait(state_e s);
        return s == PRE_FETCH || s == FETCH;
    endfunction
endpackage

// File: rtl/colpar_wait_cnt.sv
// colpar_wait_cnt: loadable down-counter that times the memory read latency
module colpar_wait_cnt #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // load wins over decrement; decrement stops at zero
    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    // counter register
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign cnt_o  = cnt_q;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/col_parity_ctrl.sv
// col_parity_ctrl: page sequencer for the theta datapath; COLPAR_CTRL_PERF_EN adds stall_cnt
module col_parity_ctrl
    import col_parity_pkg::*;
#(
    parameter int PAGES   = PAGES_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             out_ready,
`ifdef COLPAR_CTRL_PERF_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             Ready,
    output logic             Done,
    output logic [IDX_W-1:0] page_index,
    output logic             rst1,
    output logic             rst2,
    output logic             rst3,
    output logic             ld1,
    output logic             ld2,
    output logic             ld3,
    output logic             shift,
    output logic             id_rst,
    output logic             inc_i,
    output logic             out_wr
);
    localparam int              CW     = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]   LAT_M1 = CW'(MEM_LAT - 1);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(PAGES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    wcnt;
    logic             wzero, xfer, last, pf_first;

    assign xfer     = state_q == WRITE && out_ready;
    assign last     = idx_q == LAST;
    assign pf_first = state_q == PRE_FETCH && wcnt == LAT_M1;

    // the counter is loaded when a wait state is entered and runs down while in it
    colpar_wait_cnt #(.W(CW)) u_wait (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (is_wait(state_d) && state_d != state_q),
        .dec_i      (is_wait(state_q)),
        .load_val_i (LAT_M1),
        .cnt_o      (wcnt),
        .zero_o     (wzero)
    );

    // state and page index registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end

    // next-state decode; WRITE holds until downstream accepts
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = PRE_FETCH;
            PRE_FETCH: if (wzero) state_d = PRE_LATCH;
            PRE_LATCH: state_d = FETCH;
            FETCH:     if (wzero) state_d = LATCH;
            LATCH:     state_d = COMPUTE;
            COMPUTE:   state_d = WRITE;
            WRITE:     if (out_ready) state_d = last ? DONE : FETCH;
            default:   state_d = IDLE;
        endcase
    end

    // index restarts at page 0 after the wrap pre-load and returns to 0 at the end of a run
    always_comb idx_d = (state_q == PRE_LATCH || state_q == DONE) ? '0 : (xfer && !last) ? idx_q + 1'b1 : idx_q;

    // output decode; WRITE strobes depend on out_ready so a stalled slice stays put
    always_comb begin
        Ready      = state_q == IDLE;
        Done       = state_q == DONE;
        page_index = (state_q == PRE_FETCH || state_q == PRE_LATCH) ? LAST : idx_q;
        rst1       = pf_first;
        rst2       = pf_first;
        rst3       = pf_first;
        id_rst     = pf_first;
        ld1        = state_q == PRE_LATCH || xfer;
        ld2        = state_q == LATCH;
        ld3        = state_q == COMPUTE;
        shift      = xfer;
        inc_i      = xfer;
        out_wr     = state_q == WRITE;
    end

`ifdef COLPAR_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    // saturating count of back-pressured WRITE cycles, cleared when a run is accepted
    always_comb stall_d = (state_q == IDLE && start) ? '0 :
                          (state_q == WRITE && !out_ready && stall_q != 16'hFFFF) ? stall_q + 1'b1 : stall_q;

    // stall counter register
    always_ff @(posedge clk or negedge reset)
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_col_parity_ctrl.sv
// tb_col_parity_ctrl: directed bench for the column-parity sequencer (default and small configs)
module tb_col_parity_ctrl;
    logic clk = 0, rst_n = 1, start = 0, out_ready = 1, s_start = 0;
    logic rdy, dn, rst1, rst2, rst3, ld1, ld2, ld3, shift, id_rst, inc_i, out_wr;
    logic [5:0] pg;
    logic s_rdy, s_dn, s_rst1, s_rst2, s_rst3, s_ld1, s_ld2, s_ld3, s_shift, s_id_rst, s_inc_i, s_out_wr;
    logic [2:0] s_pg;
    logic [9:0] strb, s_strb;
`ifdef COLPAR_CTRL_PERF_EN
    logic [15:0] stall, s_stall;
`endif
    int tests = 0, fails = 0, ec = 0, e0 = 0, edges;
    int n_wr = 0, n_inc = 0, n_ld1 = 0, n_done = 0, n_ld2 = 0;
    int b_wr, b_inc, b_ld1, b_done, b_ld2, n, bad, fetch2, swr;
    logic [5:0] pg_log [1024];
    logic [5:0] pre_pg = '0;

    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;

    assign strb   = {rst1, rst2, rst3, ld1, ld2, ld3, shift, id_rst, inc_i, out_wr};
    assign s_strb = {s_rst1, s_rst2, s_rst3, s_ld1, s_ld2, s_ld3, s_shift, s_id_rst, s_inc_i, s_out_wr};

    col_parity_ctrl dut (
        .clk(clk), .reset(rst_n), .start(start), .out_ready(out_ready),
`ifdef COLPAR_CTRL_PERF_EN
        .stall_cnt(stall),
`endif
        .Ready(rdy), .Done(dn), .page_index(pg), .rst1(rst1), .rst2(rst2), .rst3(rst3),
        .ld1(ld1), .ld2(ld2), .ld3(ld3), .shift(shift), .id_rst(id_rst), .inc_i(inc_i), .out_wr(out_wr)
    );

    col_parity_ctrl #(.PAGES(5), .IDX_W(3), .MEM_LAT(3)) dut_s (
        .clk(clk), .reset(rst_n), .start(s_start), .out_ready(1'b1),
`ifdef COLPAR_CTRL_PERF_EN
        .stall_cnt(s_stall),
`endif
        .Ready(s_rdy), .Done(s_dn), .page_index(s_pg), .rst1(s_rst1), .rst2(s_rst2), .rst3(s_rst3),
        .ld1(s_ld1), .ld2(s_ld2), .ld3(s_ld3), .shift(s_shift), .id_rst(s_id_rst), .inc_i(s_inc_i), .out_wr(s_out_wr)
    );

    // event monitor, sampled mid-low-phase after the stimulus has settled
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (out_wr) n_wr <= n_wr + 1;
            if (inc_i) n_inc <= n_inc + 1;
            if (ld1) n_ld1 <= n_ld1 + 1;
            if (dn) n_done <= n_done + 1;
            if (ld2) begin
                pg_log[n_ld2 % 1024] <= pg;
                n_ld2 <= n_ld2 + 1;
            end
            if (ld1 && !out_wr) pre_pg <= pg;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic go();
        start = 1;
        tick();
        e0 = ec;
        start = 0;
    endtask

    task automatic wait_done(input int budget, input string tag, output int e);
        int k = 0;
        while (!dn && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, dn, 1);
        e = ec - e0;
    endtask

    task automatic snap();
        b_wr = n_wr; b_inc = n_inc; b_ld1 = n_ld1; b_done = n_done; b_ld2 = n_ld2;
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        check("rst_ready", rdy, 1);
        check("rst_done", dn, 0);
        check("rst_pg", pg, 0);
        check("rst_strb", strb, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        snap();
        go();
        wait_done(400, "run1", edges);
        check("run1_edges", edges, 258);
        tick();
        check("run1_pulse", {dn, rdy}, 2'b01);
        check("run1_wr", n_wr - b_wr, 64);
        check("run1_inc", n_inc - b_inc, 64);
        check("run1_ld1", n_ld1 - b_ld1, 65);
        check("run1_ndone", n_done - b_done, 1);
        check("run1_prepg", pre_pg, 63);
        bad = 0;
        for (int k = 0; k < 64; k++) if (pg_log[(b_ld2 + k) % 1024] != 6'(k)) bad++;
        check("run1_seq", bad, 0);
`ifdef COLPAR_CTRL_PERF_EN
        check("run1_stall", stall, 0);
`endif

        snap();
        go();
        n = 0;
        while (!(out_wr && pg == 10) && n < 400) begin tick(); n++; end
        check("stall_reach", {out_wr, pg}, {1'b1, 6'd10});
        out_ready = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("stall_strb", strb, 10'b0000000001);
            check("stall_pg", pg, 10);
            tick();
        end
        out_ready = 1;
        wait_done(400, "stall", edges);
        check("stall_edges", edges, 265);
        tick();
        check("stall_wr", n_wr - b_wr, 71);
        check("stall_inc", n_inc - b_inc, 64);
        check("stall_ld1", n_ld1 - b_ld1, 65);
`ifdef COLPAR_CTRL_PERF_EN
        check("stall_cnt7", stall, 7);
`endif

        start = 1;
        tick();
        e0 = ec;
`ifdef COLPAR_CTRL_PERF_EN
        check("held_stall_clr", stall, 0);
`endif
        wait_done(400, "held1", edges);
        check("held1_edges", edges, 258);
        tick();
        check("held_idle", {rdy, dn}, 2'b10);
        tick();
        e0 = ec;
        check("held_restart_pg", pg, 63);
        check("held_restart_strb", strb, 10'b1110000100);
        start = 0;
        wait_done(400, "held2", edges);
        check("held2_edges", edges, 258);
        tick();

        snap();
        go();
        n = 0;
        while (!(ld3 && pg == 5) && n < 400) begin tick(); n++; end
        check("cmp_reach", {ld3, pg}, {1'b1, 6'd5});
        start = 1;
        tick();
        start = 0;
        wait_done(400, "cmp", edges);
        check("cmp_edges", edges, 258);
        tick(); tick(); tick();
        check("cmp_ndone", n_done - b_done, 1);
        check("cmp_idle", rdy, 1);

        go();
        n = 0;
        while (!(pg == 17 && strb == 0 && !rdy && !dn) && n < 400) begin tick(); n++; end
        check("mid_reach", pg, 17);
        b_done = n_done;
        rst_n = 0;
        #1;
        check("mid_ready", rdy, 1);
        check("mid_done", dn, 0);
        check("mid_pg", pg, 0);
        check("mid_strb", strb, 0);
        tick();
        rst_n = 1;
        tick(); tick(); tick();
        check("mid_ndone", n_done - b_done, 0);
        check("mid_idle", rdy, 1);

        s_start = 1;
        tick();
        e0 = ec;
        s_start = 0;
        n = 0; fetch2 = 0; swr = 0;
        while (!s_dn && n < 200) begin
            if (s_pg == 2 && s_strb == 0 && !s_rdy) fetch2++;
            if (s_out_wr) swr++;
            tick();
            n++;
        end
        check("small_timeout", s_dn, 1);
        check("small_edges", ec - e0, 34);
        check("small_fetch", fetch2, 3);
        check("small_wr", swr, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
